perm_frame_buffer: RTL and testbench
====================================

# perm_frame_buffer

Frame buffer between `noc_intf`'s perm-write port (`pushin`/`firstin`/`din`/`stopin`) and the perm block's input. It collects 64-bit words into 25-word frames (one 200-byte payload), stores up to `FRAMES` complete frames, and replays each committed frame to the perm block with `stopin` backpressure honoured. Partial frames never reach the perm block. Protocol errors are flagged and dropped.

## Interface
- `WORDS`, 25: 64-bit words per frame.
- `FRAMES`, 2: frame slots (ring of banks).

- `clk`  in  1  clock; all logic on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `up_pushin`  in  1  word valid from `noc_intf`.
- `up_firstin`  in  1  marks word 0 of a frame; qualified by `up_pushin`.
- `up_din`  in  64  word data.
- `up_stopin`  out  1  registered; 1 means upstream must not push.
- `dn_pushin`  out  1  registered; word valid to perm.
- `dn_firstin`  out  1  registered; high with word 0 of each frame.
- `dn_din`  out  64  registered word data.
- `dn_stopin`  in  1  perm backpressure.
- `frame_err`  out  1  registered one-cycle pulse on any dropped word or aborted frame.
- `frames_stored`  out  $clog2(FRAMES+1)  count of committed, not yet fully sent frames.

## Operation
- Storage is `FRAMES`×`WORDS`×64 registers. Pointers:
  - `wbank`/`widx` on the write side, `rbank`/`ridx` on the read side.
  - Bank pointers wrap `FRAMES-1` to 0. Word indices wrap `WORDS-1` to 0.
- Write FSM:
  - States are WR_IDLE and WR_FILL.
  - In WR_IDLE, an accepted push with `up_firstin`=1 writes `widx`=0, sets `widx`=1 and enters WR_FILL.
  - In WR_IDLE, an accepted push with `up_firstin`=0 is dropped and pulses `frame_err`.
  - In WR_FILL, each accepted push writes `widx` and increments it.
  - On the write at `widx`=`WORDS-1`: the frame commits, `frames_stored` increments, `wbank` advances, and the FSM returns to WR_IDLE.
  - In WR_FILL, a push with `up_firstin`=1 aborts the partial frame and pulses `frame_err`. That word is written as word 0 of the same bank, `widx` becomes 1, and the FSM stays in WR_FILL.
- A push is accepted only when `up_stopin`=0. A push while `up_stopin`=1 is dropped and pulses `frame_err`. State is unchanged.
- `up_stopin` is registered and is 1 when `frames_stored`==`FRAMES` after the current cycle's updates.
- Read FSM:
  - States are RD_IDLE and RD_SEND.
  - RD_IDLE goes to RD_SEND when `frames_stored`>0.
  - In RD_SEND, each cycle with `dn_stopin`=0, the next cycle presents `mem[rbank][ridx]` with `dn_pushin`=1, `dn_firstin`=(`ridx`==0), and `ridx` increments.
  - Each cycle with `dn_stopin`=1, the next cycle has `dn_pushin`=0. `dn_din` and `ridx` hold.
  - On issuing `ridx`=`WORDS-1`: the bank is released, `frames_stored` decrements, `rbank` advances, and `ridx`=0.
  - If another frame is stored, the FSM stays in RD_SEND and that frame's word 0 may follow on the next cycle (back-to-back). Otherwise it returns to RD_IDLE.
- When a commit and a release happen in the same cycle, `frames_stored` is unchanged.
- `frame_err` ORs all error sources in a cycle into one pulse.
- The perm block must tolerate one word of skid: one word may still arrive in the cycle after it raises `dn_stopin`.

## Timing
- Values after reset (rst=0):
  - `up_stopin`=0, `dn_pushin`=0, `dn_firstin`=0, `dn_din`=0, `frame_err`=0, `frames_stored`=0.
  - All pointers are 0; FSMs are in WR_IDLE and RD_IDLE. Memory contents are don't-care.
- Reset mid-frame discards all stored and partial frames immediately (asynchronous). No output glitch beyond going to the reset values.
- Latency:
  - Last upstream word accepted at cycle t gives commit at t+1.
  - With `dn_stopin`=0, `dn_pushin`/`dn_firstin` word 0 appears at t+2.
  - An unstalled frame streams in `WORDS` consecutive cycles.
- `up_stopin` rises in the cycle after the commit that fills the last slot. It falls in the cycle after the release that frees a slot.
- `frame_err` is asserted the cycle after the offending push.

## Test plan
- Single frame, no stall:
  - Stimulus: push words 0..24 with data i, `firstin` on i=0, `dn_stopin`=0.
  - Response: `dn_pushin` high for 25 consecutive cycles starting 2 cycles after the last input. `dn_firstin` only on data 0. Data order 0..24. `frames_stored` goes 0 then 1 then 0.
- Backpressure:
  - Stimulus: during output, hold `dn_stopin`=1 for 5 cycles at word 10.
  - Response: at most one word issued after stop rises. Then `dn_pushin`=0 with `dn_din` held. On release, resume at the next word with no loss or duplicate.
- Full buffer:
  - Stimulus: `dn_stopin`=1 throughout, push 2 frames.
  - Response: `frames_stored`=2 and `up_stopin`=1.
  - Stimulus: push one more word.
  - Response: `frame_err` pulse, `frames_stored` stays 2. After `dn_stopin`=0 and frame 0 fully drained, `up_stopin`=0.
- Aborted frame:
  - Stimulus: push 10 words, then `firstin` with data 0xAA followed by 24 words.
  - Response: one `frame_err`. Output is one frame whose word 0 is 0xAA.
- Orphan push:
  - Stimulus: push with `firstin`=0 in WR_IDLE.
  - Response: `frame_err` pulse, no output.
- Back-to-back and reset:
  - Stimulus: 3 frames with continuous input and `dn_stopin`=0.
  - Response: output frames contiguous with `firstin` every 25th word. Bank wrap is correct.
  - Stimulus: assert `rst`=0 mid-frame.
  - Response: all outputs return to reset values and `frames_stored`=0.

Source files
------------

// File: rtl/perm_frame_buffer.sv
`default_nettype none
// ============================================================================
// Module   : perm_frame_buffer
// Purpose  : Collects 64-bit words from noc_intf's perm-write port into
//            WORDS-word frames and stores up to FRAMES complete frames in a
//            ring of register banks. Each committed frame is replayed to the
//            perm block, and dn_stopin backpressure is honoured. Partial
//            frames never leave the block. Protocol errors (orphan words,
//            aborted frames, pushes while stopped) are dropped and flagged.
// Ports    : clk, rst (async, active-low)
//            up_pushin/up_firstin/up_din -> word stream in
//            up_stopin                   <- registered upstream stall
//            dn_pushin/dn_firstin/dn_din <- registered word stream to perm
//            dn_stopin                   -> perm backpressure
//            frame_err                   <- one-cycle error pulse
//            frames_stored               <- committed, not fully sent frames
// Revision : 1.0 - initial release
// ============================================================================
module perm_frame_buffer #(
  parameter int WORDS  = 25,
  parameter int FRAMES = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         up_pushin,
  input  logic                         up_firstin,
  input  logic [63:0]                  up_din,
  output logic                         up_stopin,
  output logic                         dn_pushin,
  output logic                         dn_firstin,
  output logic [63:0]                  dn_din,
  input  logic                         dn_stopin,
  output logic                         frame_err,
  output logic [$clog2(FRAMES+1)-1:0]  frames_stored
);

  localparam int CW = $clog2(FRAMES + 1);
  localparam int BW = (FRAMES > 1) ? $clog2(FRAMES) : 1;
  localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [CW-1:0] FULL      = CW'(FRAMES);
  localparam logic [BW-1:0] LAST_BANK = BW'(FRAMES - 1);
  localparam logic [IW-1:0] LAST_IDX  = IW'(WORDS - 1);

  typedef enum logic {WR_IDLE = 1'b0, WR_FILL = 1'b1} wr_state_t;
  typedef enum logic {RD_IDLE = 1'b0, RD_SEND = 1'b1} rd_state_t;

  wr_state_t     wr_state;
  rd_state_t     rd_state;
  logic [BW-1:0] wbank, rbank;
  logic [IW-1:0] widx, ridx;
  logic [63:0]   mem [FRAMES][WORDS];

  logic          accept;
  logic          wr_en;
  logic [IW-1:0] wr_addr;
  logic          commit;
  logic          err;
  logic          issue;
  logic          rel;
  logic [CW-1:0] cnt_next;

  always_comb begin
    accept  = up_pushin & ~up_stopin;
    // A firstin word always restarts the current bank at word 0, which
    // covers both a fresh frame and an abort of a partial one.
    wr_en   = accept & ((wr_state == WR_FILL) | up_firstin);
    wr_addr = up_firstin ? '0 : widx;
    commit  = wr_en & ~up_firstin & (widx == LAST_IDX);
    err     = (up_pushin & up_stopin)
            | (accept & (wr_state == WR_IDLE) & ~up_firstin)
            | (accept & (wr_state == WR_FILL) &  up_firstin);

    // Issue straight from idle as soon as a frame is committed so word 0
    // reaches perm two cycles after the last upstream word.
    issue   = ~dn_stopin & ((rd_state == RD_SEND) | (frames_stored != '0));
    rel     = issue & (ridx == LAST_IDX);

    cnt_next = frames_stored;
    if (commit && !rel) begin
      cnt_next = frames_stored + CW'(1);
    end else if (rel && !commit) begin
      cnt_next = frames_stored - CW'(1);
    end
  end

  // Frame storage: contents are don't-care after reset, so no reset here.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wbank][wr_addr] <= up_din;
    end
  end

  // Write side
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_state <= WR_IDLE;
      wbank    <= '0;
      widx     <= '0;
    end else if (wr_en) begin
      if (commit) begin
        wr_state <= WR_IDLE;
        widx     <= '0;
        wbank    <= (wbank == LAST_BANK) ? '0 : wbank + BW'(1);
      end else begin
        wr_state <= WR_FILL;
        widx     <= wr_addr + IW'(1);
      end
    end
  end

  // Read side, occupancy and status
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_state      <= RD_IDLE;
      rbank         <= '0;
      ridx          <= '0;
      dn_pushin     <= 1'b0;
      dn_firstin    <= 1'b0;
      dn_din        <= '0;
      frames_stored <= '0;
      up_stopin     <= 1'b0;
      frame_err     <= 1'b0;
    end else begin
      frames_stored <= cnt_next;
      up_stopin     <= (cnt_next == FULL);
      frame_err     <= err;
      rd_state      <= (cnt_next != '0) ? RD_SEND : RD_IDLE;
      if (issue) begin
        dn_pushin  <= 1'b1;
        dn_firstin <= (ridx == '0);
        dn_din     <= mem[rbank][ridx];
        if (rel) begin
          ridx  <= '0;
          rbank <= (rbank == LAST_BANK) ? '0 : rbank + BW'(1);
        end else begin
          ridx  <= ridx + IW'(1);
        end
      end else begin
        // dn_din holds its last value while stalled
        dn_pushin  <= 1'b0;
        dn_firstin <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_perm_frame_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_perm_frame_buffer
// Purpose  : Self-checking bench for perm_frame_buffer. Expected output words
//            ({firstin, data}) are queued when a frame that must reach perm is
//            driven, and popped/compared whenever dn_pushin is sampled high.
// Revision : 1.0 - initial release
// ============================================================================
module tb_perm_frame_buffer;

  localparam int WORDS  = 25;
  localparam int FRAMES = 2;

  logic        clk;
  logic        rst;
  logic        up_pushin;
  logic        up_firstin;
  logic [63:0] up_din;
  logic        up_stopin;
  logic        dn_pushin;
  logic        dn_firstin;
  logic [63:0] dn_din;
  logic        dn_stopin;
  logic        frame_err;
  logic [1:0]  frames_stored;

  perm_frame_buffer #(.WORDS(WORDS), .FRAMES(FRAMES)) dut (
    .clk           (clk),
    .rst           (rst),
    .up_pushin     (up_pushin),
    .up_firstin    (up_firstin),
    .up_din        (up_din),
    .up_stopin     (up_stopin),
    .dn_pushin     (dn_pushin),
    .dn_firstin    (dn_firstin),
    .dn_din        (dn_din),
    .dn_stopin     (dn_stopin),
    .frame_err     (frame_err),
    .frames_stored (frames_stored)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int compares = 0;
  int errors   = 0;
  logic [64:0] sb[$];
  int run_len = 0;
  int max_run = 0;

  task automatic check(input string tag, input logic [64:0] obs, input logic [64:0] exp);
    compares++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Output monitor / scoreboard consumer
  always @(negedge clk) begin
    if (rst === 1'b1) begin
      if (dn_pushin === 1'b1) begin
        run_len++;
        if (run_len > max_run) max_run = run_len;
        if (sb.size() == 0) begin
          check("unexpected_out", {dn_firstin, dn_din}, 65'h0);
        end else begin
          check("out_word", {dn_firstin, dn_din}, sb.pop_front());
        end
      end else begin
        run_len = 0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic first, input logic [63:0] d);
    up_pushin  = 1'b1;
    up_firstin = first;
    up_din     = d;
    tick();
  endtask

  // Leaves up_pushin high; caller decides what follows.
  task automatic push_frame(input logic [63:0] base, input bit expect_out);
    for (int i = 0; i < WORDS; i++) begin
      if (expect_out) sb.push_back({(i == 0), base + 64'(i)});
      push_word(i == 0, base + 64'(i));
    end
  endtask

  task automatic wait_drain(input string tag);
    int n = 0;
    while ((sb.size() != 0 || frames_stored != 2'd0 || dn_pushin) && n < 300) begin
      tick();
      n++;
    end
    check(tag, 65'(n < 300), 65'd1);
  endtask

  initial begin
    rst        = 1'b0;
    up_pushin  = 1'b0;
    up_firstin = 1'b0;
    up_din     = '0;
    dn_stopin  = 1'b0;
    tick();
    tick();
    check("rst_up_stopin",     65'(up_stopin),     65'd0);
    check("rst_dn_pushin",     65'(dn_pushin),     65'd0);
    check("rst_dn_firstin",    65'(dn_firstin),    65'd0);
    check("rst_dn_din",        65'(dn_din),        65'd0);
    check("rst_frame_err",     65'(frame_err),     65'd0);
    check("rst_frames_stored", 65'(frames_stored), 65'd0);
    rst = 1'b1;
    tick();

    // ---------------- single frame, no stall ----------------
    push_frame(64'd0, 1'b1);
    up_pushin = 1'b0;
    check("single_commit_t1", 65'(frames_stored), 65'd1);
    check("single_nopush_t1", 65'(dn_pushin), 65'd0);
    tick();
    check("single_first_t2", 65'({dn_pushin, dn_firstin}), 65'b11);
    begin
      int ok = 1;
      for (int i = 1; i < WORDS; i++) begin
        tick();
        if (dn_pushin !== 1'b1) ok = 0;
      end
      check("single_contiguous", 65'(ok), 65'd1);
    end
    check("single_released", 65'(frames_stored), 65'd0);
    tick();
    check("single_end_push", 65'(dn_pushin), 65'd0);

    // ---------------- backpressure ----------------
    push_frame(64'd100, 1'b1);
    up_pushin = 1'b0;
    for (int i = 0; i < 10; i++) tick();   // word 9 now on the output
    check("bp_word9", 65'(dn_din), 65'd109);
    dn_stopin = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_stalled_push", 65'(dn_pushin), 65'd0);
      check("bp_stalled_hold", 65'(dn_din), 65'd109);
    end
    dn_stopin = 1'b0;
    tick();
    check("bp_resume", 65'({dn_pushin, dn_din}), {1'b1, 64'd110});
    wait_drain("bp_drain");

    // ---------------- full buffer ----------------
    dn_stopin = 1'b1;
    push_frame(64'd200, 1'b1);
    push_frame(64'd300, 1'b1);
    up_pushin = 1'b0;
    check("full_count", 65'(frames_stored), 65'd2);
    check("full_stopin", 65'(up_stopin), 65'd1);
    push_word(1'b1, 64'hDEAD);
    up_pushin = 1'b0;
    check("full_drop_err", 65'(frame_err), 65'd1);
    check("full_drop_count", 65'(frames_stored), 65'd2);
    tick();
    check("full_err_pulse", 65'(frame_err), 65'd0);
    dn_stopin = 1'b0;
    begin
      int n = 0;
      while (up_stopin && n < 60) begin
        tick();
        n++;
      end
      check("full_stopin_fall", 65'(up_stopin), 65'd0);
      check("full_after_release", 65'(frames_stored), 65'd1);
    end
    wait_drain("full_drain");

    // ---------------- aborted frame ----------------
    for (int i = 0; i < 10; i++) push_word(i == 0, 64'd400 + 64'(i));
    check("abort_no_err_yet", 65'(frame_err), 65'd0);
    sb.push_back({1'b1, 64'hAA});
    push_word(1'b1, 64'hAA);
    check("abort_err", 65'(frame_err), 65'd1);
    for (int i = 1; i < WORDS; i++) begin
      sb.push_back({1'b0, 64'h500 + 64'(i)});
      push_word(1'b0, 64'h500 + 64'(i));
    end
    up_pushin = 1'b0;
    check("abort_single_err", 65'(frame_err), 65'd0);
    wait_drain("abort_drain");

    // ---------------- orphan push ----------------
    push_word(1'b0, 64'h55);
    up_pushin = 1'b0;
    check("orphan_err", 65'(frame_err), 65'd1);
    tick();
    tick();
    tick();
    check("orphan_count", 65'(frames_stored), 65'd0);
    check("orphan_nopush", 65'(dn_pushin), 65'd0);

    // ---------------- back-to-back, bank wrap ----------------
    max_run = 0;
    push_frame(64'd600, 1'b1);
    push_frame(64'd700, 1'b1);
    push_frame(64'd800, 1'b1);
    up_pushin = 1'b0;
    wait_drain("b2b_drain");
    check("b2b_contiguous", 65'(max_run), 65'(3 * WORDS));

    // ---------------- reset mid-frame ----------------
    push_frame(64'd900, 1'b1);
    for (int i = 0; i < 5; i++) push_word(i == 0, 64'd1000 + 64'(i));
    up_pushin = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    sb.delete();
    check("mid_rst_dn_pushin", 65'(dn_pushin), 65'd0);
    check("mid_rst_dn_firstin", 65'(dn_firstin), 65'd0);
    check("mid_rst_dn_din", 65'(dn_din), 65'd0);
    check("mid_rst_count", 65'(frames_stored), 65'd0);
    check("mid_rst_stopin", 65'(up_stopin), 65'd0);
    check("mid_rst_err", 65'(frame_err), 65'd0);
    tick();
    rst = 1'b1;
    tick();
    tick();
    check("post_rst_count", 65'(frames_stored), 65'd0);
    check("post_rst_nopush", 65'(dn_pushin), 65'd0);
    push_frame(64'd1100, 1'b1);
    up_pushin = 1'b0;
    check("post_rst_commit", 65'(frames_stored), 65'd1);
    wait_drain("post_rst_drain");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compares, errors);
    $finish;
  end

  // Global time limit so the run always terminates.
  initial begin
    #200000;
    errors++;
    $display("FAIL timeout observed=running expected=finished");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compares, errors);
    $finish;
  end

endmodule
`default_nettype wire
